// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : div_unit
//  Purpose  : Multi-cycle RV32M divider (div, divu, rem, remu). Radix-2
//             restoring algorithm, one quotient bit per clock, with a
//             start/busy/done handshake for the execute-stage stall logic.
//  Revision : 1.0  initial release
// ============================================================================
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic        r_is_rem;     // remainder requested (op 2/3)
    logic        r_neg_q;      // quotient must be negated at the end
    logic        r_neg_r;      // remainder must be negated at the end
    logic [31:0] r_dvd;        // dividend shifting out, quotient shifting in
    logic [31:0] r_dvs;        // divisor magnitude
    logic [31:0] r_rem;        // partial remainder
    logic [4:0]  r_cnt;        // remaining steps minus one
    logic [31:0] r_result;

    // Operand conditioning for the accept edge.
    logic        w_signed;
    logic        w_b_zero;
    logic        w_ovf;
    logic        w_special;
    logic [31:0] w_special_result;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;

    assign w_signed  = ~op[0];
    assign w_b_zero  = (B == 32'd0);
    assign w_ovf     = w_signed && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign w_special = w_b_zero || w_ovf;
    // Divide-by-zero wins over overflow (overflow needs B==-1, so they never overlap).
    assign w_special_result = w_b_zero ? (op[1] ? A : 32'hFFFF_FFFF)
                                       : (op[1] ? 32'd0 : 32'h8000_0000);
    assign w_abs_a = (w_signed && A[31]) ? (32'd0 - A) : A;
    assign w_abs_b = (w_signed && B[31]) ? (32'd0 - B) : B;

    // One restoring step: shift in next dividend bit, trial-subtract divisor.
    logic [31:0] w_rem_sh;
    logic [32:0] w_diff;
    logic [31:0] w_rem_next;
    logic [31:0] w_dvd_next;
    logic [31:0] w_final;

    assign w_rem_sh   = {r_rem[30:0], r_dvd[31]};
    assign w_diff     = {1'b0, w_rem_sh} - {1'b0, r_dvs};
    assign w_rem_next = w_diff[32] ? w_rem_sh : w_diff[31:0];
    assign w_dvd_next = {r_dvd[30:0], ~w_diff[32]};
    // Sign flags are only ever set for signed ops, so unsigned results pass through.
    assign w_final = r_is_rem ? (r_neg_r ? (32'd0 - w_rem_next) : w_rem_next)
                              : (r_neg_q ? (32'd0 - w_dvd_next) : w_dvd_next);

    assign result = r_result;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        w_next_state = r_state;
        busy         = (r_state != c_ST_IDLE);
        done         = (r_state == c_ST_DONE);
        case (r_state)
            c_ST_IDLE: if (start) w_next_state = w_special ? c_ST_DONE : c_ST_CALC;
            c_ST_CALC: if (r_cnt == 5'd0) w_next_state = c_ST_DONE;
            c_ST_DONE: w_next_state = c_ST_IDLE;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration and result load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dvd    <= 32'd0;
            r_dvs    <= 32'd0;
            r_rem    <= 32'd0;
            r_cnt    <= 5'd0;
            r_result <= 32'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_is_rem <= op[1];
                        r_neg_q  <= w_signed & (A[31] ^ B[31]);
                        r_neg_r  <= w_signed & A[31];
                        r_dvd    <= w_abs_a;
                        r_dvs    <= w_abs_b;
                        r_rem    <= 32'd0;
                        r_cnt    <= 5'd31;
                        if (w_special) r_result <= w_special_result;
                    end
                end
                c_ST_CALC: begin
                    r_rem <= w_rem_next;
                    r_dvd <= w_dvd_next;
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd0) r_result <= w_final;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_unit
//  Purpose  : Self-checking bench for div_unit: directed cases, random ops
//             against an arithmetic reference model, reset abort, throughput.
//  Revision : 1.0  initial release
// ============================================================================
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    div_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // Reference: RV32M division semantics via 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        case (o)
            2'd0:    r = sa / sb;
            2'd1:    r = ua / ub;
            2'd2:    r = sa % sb;
            default: r = ua % ub;
        endcase
        return r[31:0];
    endfunction

    function automatic int exp_latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one operation and wait for done; optional start-poke during CALC.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit poke, output logic [31:0] res, output int lat,
                         output int busy_cyc, output bit timed_out);
        @(negedge clk);
        op = o; A = a; B = b; start = 1'b1;
        @(posedge clk);
        lat = 0; busy_cyc = 0; timed_out = 1'b0; res = 32'd0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cyc++;
            if (done) begin
                res = result;
                break;
            end
            start = 1'b0;
            if (poke && lat == 5) begin
                start = 1'b1; op = ~o; A = $urandom; B = $urandom;
            end
            if (lat >= 100) begin
                timed_out = 1'b1;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 2'd0; A = 32'd0; B = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        bit          poke;
    } vec_t;

    task automatic test_directed();
        vec_t v[12];
        logic [31:0] res;
        int lat, bc;
        bit to;
        v[0]  = '{2'd1, 32'd100,        32'd7,          32'd14,         33, 1'b0};
        v[1]  = '{2'd3, 32'd100,        32'd7,          32'd2,          33, 1'b0};
        v[2]  = '{2'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33, 1'b0};
        v[3]  = '{2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33, 1'b0};
        v[4]  = '{2'd2, 32'd7,          32'hFFFF_FFFE,  32'd1,          33, 1'b0};
        v[5]  = '{2'd0, 32'd5,          32'd0,          32'hFFFF_FFFF,  1,  1'b0};
        v[6]  = '{2'd3, 32'd5,          32'd0,          32'd5,          1,  1'b0};
        v[7]  = '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  1'b0};
        v[8]  = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  1'b0};
        v[9]  = '{2'd1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33, 1'b0};
        v[10] = '{2'd1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33, 1'b1};
        v[11] = '{2'd2, 32'hFFFF_FFF3,  32'd4,          32'hFFFF_FFFF,  33, 1'b0};
        for (int i = 0; i < 12; i++) begin
            do_op(v[i].o, v[i].a, v[i].b, v[i].poke, res, lat, bc, to);
            checks++; if (to) begin errors++; $display("FAIL dir%0d_timeout: no done within 100 cycles", i); end
            checks++; if (res !== v[i].exp) begin errors++; $display("FAIL dir%0d_result: got %h want %h", i, res, v[i].exp); end
            checks++; if (lat != v[i].lat) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, v[i].lat); end
            checks++; if (bc != v[i].lat) begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, bc, v[i].lat); end
            @(negedge clk);
            checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL dir%0d_idle_after: got busy=%b done=%b want 0 0", i, busy, done); end
            checks++; if (result !== v[i].exp) begin errors++; $display("FAIL dir%0d_hold: got %h want %h", i, result, v[i].exp); end
        end
    endtask

    task automatic test_random();
        logic [31:0] res, a, b;
        logic [1:0]  o;
        int lat, bc, sel;
        bit to;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0:       b = 32'd0;
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       b = $urandom_range(1, 15);
                3:       b = $urandom >> $urandom_range(0, 31);
                4:       b = 32'd0 - $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            do_op(o, a, b, 1'b0, res, lat, bc, to);
            checks++; if (to || res !== model(o, a, b)) begin errors++;
                $display("FAIL rnd%0d_result: op=%0d a=%h b=%h got %h want %h", i, o, a, b, res, model(o, a, b)); end
            checks++; if (lat != exp_latency(o, a, b)) begin errors++;
                $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, exp_latency(o, a, b)); end
        end
    endtask

    task automatic test_rst_mid_calc();
        logic [31:0] res;
        int lat, bc;
        bit seen;
        bit to;
        @(negedge clk);
        op = 2'd0; A = 32'd1000; B = 32'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", done); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL rstmid_result: got %h want 0", result); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL rstmid_no_done: got activity=1 want 0"); end
        do_op(2'd1, 32'd9, 32'd3, 1'b0, res, lat, bc, to);
        checks++; if (to || res !== 32'd3) begin errors++; $display("FAIL rstmid_next_result: got %h want 3", res); end
        checks++; if (lat != 33) begin errors++; $display("FAIL rstmid_next_latency: got %0d want 33", lat); end
    endtask

    task automatic test_back_to_back();
        int k;
        bit idle_seen;
        @(negedge clk);
        op = 2'd1; A = 32'd1000; B = 32'd10; start = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!done && k < 100);
        checks++; if (k != 33) begin errors++; $display("FAIL b2b_first_latency: got %0d want 33", k); end
        k = 0; idle_seen = 1'b0;
        do begin
            @(negedge clk); k++;
            if (k == 1 && busy === 1'b0) idle_seen = 1'b1;
        end while (!done && k < 100);
        start = 1'b0;
        checks++; if (k != 34) begin errors++; $display("FAIL b2b_spacing: got %0d want 34", k); end
        checks++; if (!idle_seen) begin errors++; $display("FAIL b2b_busy_drop: got busy=1 want 0 after done"); end
        checks++; if (result !== 32'd100) begin errors++; $display("FAIL b2b_result: got %h want %h", result, 32'd100); end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_rst_mid_calc();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_unit.md
# div_unit

Multi-cycle integer divider for the execute stage. It provides the RV32M division instructions (div, divu, rem, remu) that the single-cycle ALU does not cover. It uses a radix-2 restoring algorithm, one quotient bit per clock, with a start/busy/done handshake. The pipeline stalls on `busy`, and the decoded instruction's result is taken when `done` is high.

## Interface
Parameters:
- none; width fixed at 32 bits

Ports:
- `clk`  in  1  — single clock, rising edge
- `rst`  in  1  — synchronous, active-high reset
- `start`  in  1  — request; sampled only in IDLE
- `op`  in  2  — 0 div (signed quotient), 1 divu, 2 rem (signed remainder), 3 remu
- `A`  in  32  — dividend
- `B`  in  32  — divisor
- `busy`  out  1  — high whenever state is not IDLE
- `done`  out  1  — one-cycle pulse; `result` is valid while high
- `result`  out  32  — quotient or remainder; held until the next accepted start

## Operation
- States: IDLE, CALC, DONE.
- **IDLE, start=1:**
  - Latch `op`, `A`, `B`.
  - Special case takes priority and goes directly to DONE with `result` loaded:
    - B==0:
      - div/divu → 0xFFFFFFFF
      - rem/remu → A
    - Signed overflow (op div/rem, A==0x80000000, B==0xFFFFFFFF):
      - div → 0x80000000
      - rem → 0
  - Otherwise:
    - Signed ops: |A| → dividend shift reg, |B| → divisor.
    - Record neg_q = A[31]^B[31] and neg_r = A[31].
    - Unsigned ops: no sign processing.
    - Clear the partial remainder; set the counter to 31; go to CALC.
- **CALC step (one per cycle):**
  - Form rem' = {rem[30:0], dvd[31]}.
  - Compute diff = {1'b0, rem'} − {1'b0, divisor} (33 bits).
  - diff[32]==0: rem ← diff[31:0], quotient bit = 1.
  - diff[32]==1: rem ← rem', quotient bit = 0.
  - Shift the quotient bit into dvd LSB (the dividend register becomes the quotient).
  - Decrement the counter.
- **CALC, counter==0:**
  - Perform the step, then load `result` in the same edge:
    - quotient, negated if neg_q (div), or
    - remainder, negated if neg_r (rem).
  - Unsigned ops take no negation.
  - Go to DONE.
- **DONE:** `done`=1, `busy`=1; go to IDLE next edge. `start` is ignored in DONE.
- `start` is ignored in CALC and DONE; the latched operands are unaffected.
- Arithmetic rules:
  - Two's-complement negation modulo 2^32.
  - Quotient truncates toward zero.
  - Remainder sign follows the dividend; magnitude is less than |B|.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, internal regs 0.
- `rst` in any state (including mid-CALC) returns to IDLE next edge. The operation is abandoned and no `done` is produced.
- Accept edge = edge at which IDLE and start=1.
- Normal latency:
  - 32 CALC edges after the accept edge.
  - `done` is high in the cycle following the 32nd, i.e. 33 cycles after the accept edge.
  - `busy` is high for 33 cycles.
- Special-case latency: `done` is high in the cycle right after the accept edge; `busy` is high for exactly that one cycle.
- Back-to-back:
  - `busy` falls with the DONE→IDLE transition.
  - The next start can be accepted on the edge after the `done` cycle, so a new operation is accepted every 34 cycles minimum.
- `result` changes only on the edge entering DONE or on reset.

## Test plan
- divu A=100, B=7 → result=14, `done` 33 cycles after accept; remu same operands → 2.
- div A=−7 (0xFFFFFFF9), B=2 → 0xFFFFFFFD (−3); rem → 0xFFFFFFFF (−1); rem A=7, B=−2 → 1.
- div A=5, B=0 → 0xFFFFFFFF; remu A=5, B=0 → 5; both with `done` one cycle after accept and `busy` high one cycle.
- div A=0x80000000, B=0xFFFFFFFF → 0x80000000; rem → 0; both on the 1-cycle path. divu same operands → 0 after 33 cycles.
- divu A=0xFFFFFFFF, B=1 → 0xFFFFFFFF. Assert start with different operands during CALC → ignored; result and latency unchanged.
- Start div A=1000, B=3, then assert `rst` on cycle 10 of CALC. Required: `busy`=0 and `done`=0 next cycle, no `done` pulse afterwards, `result`=0. A new divu 9/3 then returns 3 normally.
